rx_frame_filter: RTL and testbench
==================================

RX_FRAME_FILTER -- requirements
Module: rx_frame_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXIS data width in bits; fixed at 32 (DATA_NBYTES = 4).
REQ-002 Parameter ADDR_WIDTH, default 9: buffer depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  sole clock (MAC rx clock domain).
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 s00_axis_tdata/tkeep/tvalid/tlast/tuser  in  32/4/1/1/1  MAC rx stream, no tready; a beat with tlast and tuser=0 marks a bad-CRC frame; a tlast beat may carry tkeep=0.
REQ-007 m00_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  32/4/1/1/1  standard AXIS stream of good frames only; tkeep is never 0 on any output beat.
REQ-008 o_drop_crc  out  1  one-cycle pulse per frame dropped for bad CRC.
REQ-009 o_drop_overflow  out  1  one-cycle pulse per frame dropped for buffer overflow.
REQ-010 o_drop_count  out  16  saturating count of dropped frames (both causes).

Function
REQ-011 Store-and-forward: no beat of a frame appears on m00 before that frame is committed.
REQ-012 RAM word = {tlast, tkeep, tdata}, 37 bits; write pointer wr_ptr, committed pointer commit_ptr, read pointer rd_ptr, each ADDR_WIDTH+1 bits, wrapping modulo 2*DEPTH.
REQ-013 Input staging register holds one beat; each new valid non-tlast beat writes the staged beat (last=0) and replaces it.
REQ-014 On the tlast beat at cycle T with tkeep=0: staged beat is written with last=1 at T and commit occurs at T; with tkeep!=0: staged beat is written at T (last=0), tlast beat written at T+1 with last=1, and commit occurs at T+1.
REQ-015 Input is guaranteed to have at least one invalid cycle after each tlast beat (Ethernet IPG); the block does not need to accept a beat at T+1.
REQ-016 Write FSM states: IDLE (no frame open), RECV (frame open), DROP (discarding to tlast).
REQ-017 IDLE->RECV on first valid beat; RECV->IDLE on tlast; RECV->DROP when a write would make wr_ptr-rd_ptr exceed DEPTH-1; DROP->IDLE on tlast.
REQ-018 Commit (tuser=1, not DROP): commit_ptr <= wr_ptr after the final write.
REQ-019 Bad CRC (tlast with tuser=0, in RECV): wr_ptr <= commit_ptr, staging cleared, o_drop_crc pulses at T+1, o_drop_count increments.
REQ-020 Overflow: on tlast in DROP, wr_ptr <= commit_ptr, o_drop_overflow pulses at T+1, count increments; tuser ignored.
REQ-021 A frame with tlast, tkeep=0 and no staged beat (zero data) is discarded silently, no pulse, no count.
REQ-022 Read side: RAM read registered (1 cycle) plus output register; reads issued only while rd_ptr != commit_ptr and a pipeline slot is free.
REQ-023 With tready held high, output sustains one beat per cycle with no bubbles within or between committed frames.
REQ-024 Empty buffer, tkeep!=0 tlast at T: m00_axis_tvalid first high at T+4; tkeep=0 tlast: T+3.
REQ-025 m00 data/tkeep/tlast hold stable while tvalid=1 and tready=0.
REQ-026 o_drop_count saturates at 16'hFFFF.

Reset
REQ-027 On i_reset: all pointers 0, FSM IDLE, staging empty, m00_axis_tvalid=0, m00_axis_tdata/tkeep/tlast=0, o_drop_crc=0, o_drop_overflow=0, o_drop_count=0.
REQ-028 Input beats during reset are ignored; a frame in progress at reset is discarded without pulse; the first valid beat after reset deasserts starts a new frame.

Structure
REQ-029 DATA_WIDTH, DATA_NBYTES and the write-FSM state enum live in the shared ethernet package.
REQ-030 Storage is one sub-module, sdp_ram: simple dual-port, one write port, one registered read port, parameterised width/depth.

Verification
REQ-031 Good 16-beat frame, all tkeep=4'hF, tuser=1 at tlast -> 16 identical output beats, tlast on 16th, tvalid first at T+4.
REQ-032 Same frame with tuser=0 -> no output, o_drop_crc high for exactly cycle T+1, o_drop_count=1.
REQ-033 15 data beats then tlast beat with tkeep=0 -> 15 output beats, tlast on beat 15 with its original tkeep, tvalid first at T+3.
REQ-034 ADDR_WIDTH=4, tready=0, 20-beat good frame then 4-beat good frame -> first dropped, o_drop_overflow pulse; after tready=1 only 4-beat frame emerges.
REQ-035 Two back-to-back good frames (8 and 3 beats, last tkeep=4'h1) with tready toggling 1/0 -> all 11 beats in order, data held stable while stalled.
REQ-036 i_reset asserted at beat 5 of a 10-beat frame -> outputs at reset values next cycle; subsequent good 4-beat frame output intact, o_drop_count=0.

Source files
------------

// File: rtl/rx_frame_filter_pkg.sv
// rtl/rx_frame_filter_pkg.sv - shared ethernet constants and write-side state type
package rx_frame_filter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RECV = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
    parameter int WIDTH      = 37,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // registered read port; output holds when no read is issued
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_frame_filter.sv
// rtl/rx_frame_filter.sv - store-and-forward filter dropping bad-CRC and overflowing rx frames
module rx_frame_filter #(
    parameter int DATA_WIDTH = rx_frame_filter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tkeep,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    input  logic                    s00_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                    m00_axis_tvalid,
    input  logic                    m00_axis_tready,
    output logic                    m00_axis_tlast,
    output logic                    o_drop_crc,
    output logic                    o_drop_overflow,
    output logic [15:0]             o_drop_count
);

    import rx_frame_filter_pkg::*;

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int WORD_W = 1 + KEEP_W + DATA_WIDTH;
    localparam int PW     = ADDR_WIDTH + 1;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [PW:0] MAX_OCC = (PW+1)'(DEPTH - 1);

    wr_state_t state, state_n;

    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] commit_ptr, commit_ptr_n;
    logic [PW-1:0] rd_ptr;

    logic                  stg_valid, stg_valid_n;
    logic                  stg_fin, stg_fin_n;
    logic                  stg_load;
    logic [DATA_WIDTH-1:0] stg_data;
    logic [KEEP_W-1:0]     stg_keep;

    logic              ram_we;
    logic              ram_wlast;
    logic [WORD_W-1:0] ram_rdata;
    logic              ram_valid;
    logic              rd_en;
    logic              out_ready;

    logic       crc_evt, ovf_evt;
    logic       keep_nz;
    logic [1:0] need;
    logic [PW:0] occ_after;
    logic       fits;

    // space check: words already written (committed or not) plus the words this beat commits to
    always_comb begin
        keep_nz   = (s00_axis_tkeep != '0);
        need      = s00_axis_tlast ? ({1'b0, stg_valid} + {1'b0, keep_nz}) : 2'd1;
        occ_after = {1'b0, wr_ptr - rd_ptr} + (PW+1)'(need);
        fits      = (occ_after <= MAX_OCC);
    end

    // write FSM next state plus staging, write and commit decisions
    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        stg_valid_n  = stg_valid;
        stg_fin_n    = 1'b0;
        stg_load     = 1'b0;
        ram_we       = 1'b0;
        ram_wlast    = 1'b0;
        crc_evt      = 1'b0;
        ovf_evt      = 1'b0;
        if (stg_fin) begin
            // second half of a tlast beat carrying data: store it as the frame's last word
            ram_we       = 1'b1;
            ram_wlast    = 1'b1;
            wr_ptr_n     = wr_ptr + PW'(1);
            commit_ptr_n = wr_ptr + PW'(1);
            stg_valid_n  = 1'b0;
        end else if (s00_axis_tvalid) begin
            case (state)
                WR_DROP: begin
                    if (s00_axis_tlast) begin
                        state_n     = WR_IDLE;
                        wr_ptr_n    = commit_ptr;
                        stg_valid_n = 1'b0;
                        ovf_evt     = 1'b1;
                    end
                end
                default: begin
                    if (!s00_axis_tlast) begin
                        state_n = WR_RECV;
                        if (stg_valid && !fits) begin
                            state_n     = WR_DROP;
                            stg_valid_n = 1'b0;
                        end else begin
                            if (stg_valid) begin
                                ram_we   = 1'b1;
                                wr_ptr_n = wr_ptr + PW'(1);
                            end
                            stg_load    = 1'b1;
                            stg_valid_n = 1'b1;
                        end
                    end else begin
                        state_n = WR_IDLE;
                        // a frame with no data at all vanishes without a trace
                        if (keep_nz || stg_valid) begin
                            if (!s00_axis_tuser) begin
                                crc_evt     = 1'b1;
                                wr_ptr_n    = commit_ptr;
                                stg_valid_n = 1'b0;
                            end else if (!fits) begin
                                ovf_evt     = 1'b1;
                                wr_ptr_n    = commit_ptr;
                                stg_valid_n = 1'b0;
                            end else if (!keep_nz) begin
                                ram_we       = 1'b1;
                                ram_wlast    = 1'b1;
                                wr_ptr_n     = wr_ptr + PW'(1);
                                commit_ptr_n = wr_ptr + PW'(1);
                                stg_valid_n  = 1'b0;
                            end else begin
                                if (stg_valid) begin
                                    ram_we   = 1'b1;
                                    wr_ptr_n = wr_ptr + PW'(1);
                                end
                                stg_load    = 1'b1;
                                stg_valid_n = 1'b1;
                                stg_fin_n   = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // write FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= WR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // write pointers and staging flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            stg_valid  <= 1'b0;
            stg_fin    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            commit_ptr <= commit_ptr_n;
            stg_valid  <= stg_valid_n;
            stg_fin    <= stg_fin_n;
        end
    end

    // staging register contents
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stg_data <= '0;
            stg_keep <= '0;
        end else if (stg_load) begin
            stg_data <= s00_axis_tdata;
            stg_keep <= s00_axis_tkeep;
        end
    end

    // drop pulses and saturating drop counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_drop_crc      <= 1'b0;
            o_drop_overflow <= 1'b0;
            o_drop_count    <= '0;
        end else begin
            o_drop_crc      <= crc_evt;
            o_drop_overflow <= ovf_evt;
            if ((crc_evt || ovf_evt) && (o_drop_count != 16'hFFFF)) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end
    end

    sdp_ram #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we && !i_reset),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata ({ram_wlast, stg_keep, stg_data}),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // read only committed words, and only when the RAM output stage will have somewhere to go
    always_comb begin
        out_ready = !m00_axis_tvalid || m00_axis_tready;
        rd_en     = !i_reset && (rd_ptr != commit_ptr) && (!ram_valid || out_ready);
    end

    // read pointer, RAM output stage and output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr          <= '0;
            ram_valid       <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m00_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr    <= rd_ptr + PW'(1);
                ram_valid <= 1'b1;
            end else if (out_ready) begin
                ram_valid <= 1'b0;
            end
            if (out_ready) begin
                m00_axis_tvalid <= ram_valid;
                if (ram_valid) begin
                    {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_filter.sv
// tb/tb_rx_frame_filter.sv - randomized self-checking bench for rx_frame_filter
module tb_rx_frame_filter;

    localparam int SMALL_AW    = 4;
    localparam int SMALL_DEPTH = 1 << SMALL_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser;
    logic        m_tready;

    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep;
    logic        b_tvalid, b_tlast, b_crc, b_ovf;
    logic [15:0] b_cnt;

    logic [31:0] q_tdata;
    logic [3:0]  q_tkeep;
    logic        q_tvalid, q_tlast, q_crc, q_ovf;
    logic [15:0] q_cnt;

    rx_frame_filter #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .i_clk(clk), .i_reset(rst),
        .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
        .m00_axis_tdata(b_tdata), .m00_axis_tkeep(b_tkeep), .m00_axis_tvalid(b_tvalid),
        .m00_axis_tready(m_tready), .m00_axis_tlast(b_tlast),
        .o_drop_crc(b_crc), .o_drop_overflow(b_ovf), .o_drop_count(b_cnt)
    );

    rx_frame_filter #(.DATA_WIDTH(32), .ADDR_WIDTH(SMALL_AW)) dut_small (
        .i_clk(clk), .i_reset(rst),
        .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
        .m00_axis_tdata(q_tdata), .m00_axis_tkeep(q_tkeep), .m00_axis_tvalid(q_tvalid),
        .m00_axis_tready(m_tready), .m00_axis_tlast(q_tlast),
        .o_drop_crc(q_crc), .o_drop_overflow(q_ovf), .o_drop_count(q_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    logic [36:0] sb[$];
    logic [36:0] sq[$];
    int exp_crc, exp_drops, crc_pulses, ovf_pulses, last_crc_cyc, first_valid_cyc;
    bit sm_en;
    int sm_occ, sm_exp_ovf, sm_ovf_pulses;
    int rdy_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_model();
        sb.delete(); sq.delete();
        exp_crc = 0; exp_drops = 0; crc_pulses = 0; ovf_pulses = 0;
        last_crc_cyc = -1; first_valid_cyc = -1;
        sm_occ = 0; sm_exp_ovf = 0; sm_ovf_pulses = 0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic last, input logic user);
        s_tdata = d; s_tkeep = k; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tkeep = '0; s_tdata = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // expected output of a frame: non-last beats verbatim, an empty tlast beat folds into its predecessor
    task automatic send_frame(input int n, input logic [3:0] last_keep, input logic user,
                              input int gap, output int t_last);
        logic [31:0] dat[$];
        logic [36:0] beats[$];
        for (int i = 0; i < n; i++) dat.push_back($urandom);
        for (int i = 0; i < n - 1; i++) beats.push_back({1'b0, 4'hF, dat[i]});
        if (last_keep != 4'h0) beats.push_back({1'b1, last_keep, dat[n-1]});
        else if (beats.size() > 0) beats[beats.size()-1][36] = 1'b1;
        if (beats.size() > 0) begin
            if (!user) begin
                exp_crc++; exp_drops++;
            end else begin
                foreach (beats[i]) sb.push_back(beats[i]);
                if (sm_en) begin
                    if (sm_occ + beats.size() <= SMALL_DEPTH - 1) begin
                        sm_occ += beats.size();
                        foreach (beats[i]) sq.push_back(beats[i]);
                    end else begin
                        sm_exp_ovf++;
                    end
                end
            end
        end
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                t_last = cyc;
                drive_beat(dat[i], last_keep, 1'b1, user);
            end else begin
                drive_beat(dat[i], 4'hF, 1'b0, 1'b0);
            end
        end
        idle(gap);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || sq.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, sb.size() + sq.size(), 0);
        idle(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_model();
    endtask

    // output ready pattern
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = ($urandom_range(0, 3) != 0);
                2: m_tready = ~m_tready;
                default: m_tready = 1'b0;
            endcase
        end
    end

    // output monitors: while valid the beat must equal the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (b_crc) begin crc_pulses++; last_crc_cyc = cyc; end
            if (b_ovf) ovf_pulses++;
            if (b_tvalid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sb.size() == 0) check("big_extra_beat", b_tvalid, 1'b0);
                else begin
                    check("big_beat", {b_tlast, b_tkeep, b_tdata}, sb[0]);
                    if (m_tready) void'(sb.pop_front());
                end
            end
            if (sm_en) begin
                if (q_ovf) sm_ovf_pulses++;
                if (q_tvalid) begin
                    if (sq.size() == 0) check("small_extra_beat", q_tvalid, 1'b0);
                    else begin
                        check("small_beat", {q_tlast, q_tkeep, q_tdata}, sq[0]);
                        if (m_tready) void'(sq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        check("watchdog_done", done, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        int t, c0;
        rst = 1'b1; sm_en = 1'b0; rdy_mode = 0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tkeep = '0; s_tdata = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", b_tvalid, 1'b0);
        check("rst_tdata", b_tdata, 32'h0);
        check("rst_tkeep", b_tkeep, 4'h0);
        check("rst_tlast", b_tlast, 1'b0);
        check("rst_crc", b_crc, 1'b0);
        check("rst_ovf", b_ovf, 1'b0);
        check("rst_count", b_cnt, 16'h0);
        @(posedge clk); #1;

        // good 16-beat frame
        first_valid_cyc = -1;
        send_frame(16, 4'hF, 1'b1, 2, t);
        wait_drain(200, "drain_good16");
        check("latency_keep_full", first_valid_cyc - t, 4);

        // same frame with bad CRC
        c0 = crc_pulses;
        send_frame(16, 4'hF, 1'b0, 4, t);
        check("crc_pulse_count", crc_pulses - c0, 1);
        check("crc_pulse_cycle", last_crc_cyc, t + 1);
        check("crc_drop_count", b_cnt, exp_drops);

        // 15 data beats then an empty tlast beat
        first_valid_cyc = -1;
        send_frame(16, 4'h0, 1'b1, 2, t);
        wait_drain(200, "drain_keep0");
        check("latency_keep_zero", first_valid_cyc - t, 3);

        // back-to-back frames under toggling ready
        rdy_mode = 2;
        send_frame(8, 4'hF, 1'b1, 1, t);
        send_frame(3, 4'h1, 1'b1, 1, t);
        wait_drain(200, "drain_toggle");

        // randomized traffic
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            logic [3:0] lk;
            n = $urandom_range(1, 12);
            case ($urandom_range(0, 4))
                0: lk = 4'h0;
                1: lk = 4'h1;
                2: lk = 4'h3;
                3: lk = 4'h7;
                default: lk = 4'hF;
            endcase
            send_frame(n, lk, ($urandom_range(0, 4) != 0), $urandom_range(1, 3), t);
        end
        rdy_mode = 0;
        wait_drain(2000, "drain_random");
        check("random_crc_pulses", crc_pulses, exp_crc);
        check("random_drop_count", b_cnt, exp_drops);
        check("random_ovf_pulses", ovf_pulses, 0);

        // overflow in the 16-word instance with output stalled
        do_reset();
        sm_en = 1'b1;
        rdy_mode = 3;
        idle(2);
        send_frame(20, 4'hF, 1'b1, 2, t);
        send_frame(4, 4'hF, 1'b1, 3, t);
        check("small_ovf_pulses", sm_ovf_pulses, sm_exp_ovf);
        check("small_drop_count", q_cnt, sm_exp_ovf);
        rdy_mode = 0;
        wait_drain(300, "drain_overflow");
        check("big_no_ovf", ovf_pulses, 0);
        sm_en = 1'b0;
        sq.delete();

        // reset in the middle of a frame
        for (int i = 0; i < 4; i++) drive_beat($urandom, 4'hF, 1'b0, 1'b0);
        s_tdata = $urandom; s_tkeep = 4'hF; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
        @(negedge clk);
        check("mid_rst_tvalid", b_tvalid, 1'b0);
        check("mid_rst_tdata", b_tdata, 32'h0);
        check("mid_rst_tkeep", b_tkeep, 4'h0);
        check("mid_rst_tlast", b_tlast, 1'b0);
        check("mid_rst_count", b_cnt, 16'h0);
        @(posedge clk); #1;
        send_frame(4, 4'h7, 1'b1, 2, t);
        wait_drain(200, "drain_after_reset");
        check("after_rst_count", b_cnt, exp_drops);
        check("after_rst_pulses", crc_pulses + ovf_pulses, 0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
